// File: rtl/uart_receiver_if.sv
// Receive-side signal bundle: raw serial line in, received byte and status pulses out.
// The master side is the receiver; the slave side is the board pin and the byte consumer.
`timescale 1ns/1ps
interface uart_receiver_if;
  logic       in_serial;
  logic       active;
  logic [7:0] out_data;
  logic       data_valid;
  logic       frame_error;

  modport master (
    input  in_serial,
    output active,
    output out_data,
    output data_valid,
    output frame_error
  );

  modport slave (
    output in_serial,
    input  active,
    input  out_data,
    input  data_valid,
    input  frame_error
  );
endinterface

// File: rtl/uart_receiver.sv
// 8N1 UART receiver: two-flop synchroniser, start-glitch rejection, mid-bit sampling,
// framing-error detection with break handling.
`timescale 1ns/1ps
module uart_receiver #(
  parameter int clocks_per_bit = 217
) (
  input  logic            clk,
  input  logic            rst_n,
  uart_receiver_if.master bus
);

  localparam int CW = $clog2(clocks_per_bit) + 1;
  localparam logic [CW-1:0] HALF = CW'((clocks_per_bit - 1) / 2);
  localparam logic [CW-1:0] LAST = CW'(clocks_per_bit - 1);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    START_BIT = 3'd1,
    DATA_BITS = 3'd2,
    STOP_BIT  = 3'd3,
    WAIT_HIGH = 3'd4
  } state_t;

  logic          sync_p0;
  logic          rx_s;
  state_t        state, state_next;
  logic [CW-1:0] clock_count, count_next;
  logic [2:0]    index, index_next;
  logic [7:0]    buffer, buffer_next;
  logic [7:0]    out_data_q, out_data_next;
  logic          active_q, active_next;
  logic          data_valid_q, data_valid_next;
  logic          frame_error_q, frame_error_next;

  // Synchroniser resets to the idle (high) line level so reset never looks like a start edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_p0 <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      sync_p0 <= bus.in_serial;
      rx_s    <= sync_p0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      clock_count   <= '0;
      index         <= '0;
      buffer        <= '0;
      out_data_q    <= '0;
      active_q      <= 1'b0;
      data_valid_q  <= 1'b0;
      frame_error_q <= 1'b0;
    end else begin
      state         <= state_next;
      clock_count   <= count_next;
      index         <= index_next;
      buffer        <= buffer_next;
      out_data_q    <= out_data_next;
      active_q      <= active_next;
      data_valid_q  <= data_valid_next;
      frame_error_q <= frame_error_next;
    end
  end

  always_comb begin
    state_next       = state;
    count_next       = clock_count;
    index_next       = index;
    buffer_next      = buffer;
    out_data_next    = out_data_q;
    active_next      = active_q;
    data_valid_next  = 1'b0;
    frame_error_next = 1'b0;

    case (state)
      IDLE: begin
        count_next = '0;
        index_next = '0;
        if (!rx_s) begin
          state_next  = START_BIT;
          active_next = 1'b1;
        end
      end

      // A line that is high again by mid start bit was only a glitch
      START_BIT: begin
        if (clock_count < HALF) begin
          count_next = clock_count + CW'(1);
        end else if (!rx_s) begin
          count_next = '0;
          state_next = DATA_BITS;
        end else begin
          state_next  = IDLE;
          active_next = 1'b0;
        end
      end

      DATA_BITS: begin
        if (clock_count < LAST) begin
          count_next = clock_count + CW'(1);
        end else begin
          buffer_next[index] = rx_s;
          count_next         = '0;
          if (index < 3'd7) begin
            index_next = index + 3'd1;
          end else begin
            index_next = '0;
            state_next = STOP_BIT;
          end
        end
      end

      // Returning to IDLE at mid stop bit lets a back-to-back start edge be caught
      STOP_BIT: begin
        if (clock_count < LAST) begin
          count_next = clock_count + CW'(1);
        end else begin
          count_next  = '0;
          active_next = 1'b0;
          if (rx_s) begin
            out_data_next   = buffer;
            data_valid_next = 1'b1;
            state_next      = IDLE;
          end else begin
            frame_error_next = 1'b1;
            state_next       = WAIT_HIGH;
          end
        end
      end

      // A held-low break must not re-trigger reception
      WAIT_HIGH: begin
        if (rx_s) state_next = IDLE;
      end

      default: begin
        state_next  = IDLE;
        active_next = 1'b0;
      end
    endcase
  end

  assign bus.active      = active_q;
  assign bus.out_data    = out_data_q;
  assign bus.data_valid  = data_valid_q;
  assign bus.frame_error = frame_error_q;

endmodule
